// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline sequencer resolving load-use, redirect and memory-wait hazards
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_we,
    output logic             id_ex_flush,
    output logic             ex_mem_we,
    output logic             ex_mem_flush,
    output logic             mem_wb_we,
    output logic             mem_wb_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {INIT, RUN, MEM_WAIT} state_t;

    state_t           state_q, state_d;
    logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             forced, freeze, loaduse, stall_ev, flush_ev;

    assign forced  = (state_q == MEM_WAIT) && (wait_cnt_q == WW'(MEM_TIMEOUT));
    assign freeze  = dmem_req && !dmem_ready && !forced;
    assign loaduse = ex_mem_read && (ex_rd != 5'd0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    assign mem_timeout = forced;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

    assign stall_cnt_d = (stall_ev && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    assign flush_cnt_d = (flush_ev && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;

    // State, wait counter and saturating performance counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= INIT;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Priority hazard resolution (freeze > redirect > loaduse) and next state
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_we     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_we    = 1'b1;
        ex_mem_flush = 1'b0;
        mem_wb_we    = 1'b1;
        mem_wb_flush = 1'b0;
        stall_ev     = 1'b0;
        flush_ev     = 1'b0;
        if (state_q == INIT) begin
            pc_we        = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
            state_d      = RUN;
            wait_cnt_d   = '0;
        end else begin
            if (freeze) begin
                pc_we        = 1'b0;
                if_id_we     = 1'b0;
                id_ex_we     = 1'b0;
                ex_mem_we    = 1'b0;
                mem_wb_flush = 1'b1;
                stall_ev     = 1'b1;
            end else if (ex_redirect) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                flush_ev    = 1'b1;
            end else if (loaduse) begin
                pc_we       = 1'b0;
                if_id_we    = 1'b0;
                id_ex_flush = 1'b1;
                stall_ev    = 1'b1;
            end
            state_d    = freeze ? MEM_WAIT : RUN;
            wait_cnt_d = freeze ? wait_cnt_q + WW'(1) : '0;
        end
    end
endmodule
